// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
// -------------
// Shares the single write port of the 32x32 register file between two
// writeback requesters (A: ALU/immediate path, B: load path) and runs a
// software-triggered sequence that writes CLR_VALUE to r1..r31.
//
// Parameters
//   CLR_VALUE   data written to each register during a clear sequence
//   DISCARD_R0  1: granted writes to r0 are acked but RegWr stays 0
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   clr_req    in   start a clear sequence (sampled only in IDLE)
//   clr_busy   out  high while the sequencer is in CLEAR
//   a_req      in   requester A wants a write
//   a_addr     in   A destination register
//   a_data     in   A write data
//   a_ack      out  one-cycle pulse: A request issued to the port
//   b_req/b_addr/b_data/b_ack   same as A, for requester B
//   RegWr      out  register-file write enable (registered)
//   WrAddr     out  register-file write address (registered)
//   DataIn     out  register-file write data (registered)
//   dbg_state  out  current FSM state (0 = IDLE, 1 = CLEAR)
//   dbg_prio   out  current round-robin pointer (0 = A, 1 = B)
//
// Handshake: a requester raises x_req with x_addr/x_data stable and holds
// them until it sees x_ack=1. The ack is a single-cycle pulse issued in the
// same cycle as the corresponding RegWr/WrAddr/DataIn. In the ack cycle the
// side is masked from arbitration, so the requester may drop req or present
// a fresh request at the next edge without being granted twice.
module rf_wr_arbiter #(
    parameter logic [31:0] CLR_VALUE  = 32'h0000_0000,
    parameter bit          DISCARD_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_req,
    output logic        clr_busy,
    input  logic        a_req,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ack,
    output logic        RegWr,
    output logic [4:0]  WrAddr,
    output logic [31:0] DataIn,
    output logic        dbg_state,
    output logic        dbg_prio
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    state_t      state, state_next;
    logic        prio, prio_next;
    logic [4:0]  cnt, cnt_next;

    logic        regwr_next;
    logic [4:0]  wraddr_next;
    logic [31:0] datain_next;
    logic        a_ack_next, b_ack_next;

    logic        a_elig, b_elig;
    logic        grant_a, grant_b;

    // A side still in its ack cycle is masked so a held request is not
    // granted a second time.
    assign a_elig  = a_req & ~a_ack;
    assign b_elig  = b_req & ~b_ack;
    assign grant_a = a_elig & (~b_elig | (prio == PRIO_A));
    assign grant_b = b_elig & ~grant_a;

    always_comb begin
        state_next  = state;
        prio_next   = prio;
        cnt_next    = cnt;
        regwr_next  = 1'b0;
        wraddr_next = WrAddr;
        datain_next = DataIn;
        a_ack_next  = 1'b0;
        b_ack_next  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    // Clear wins over pending requests; they stay pending.
                    state_next = ST_CLEAR;
                    cnt_next   = 5'd1;
                end else if (grant_a) begin
                    wraddr_next = a_addr;
                    datain_next = a_data;
                    regwr_next  = !(DISCARD_R0 && (a_addr == 5'd0));
                    a_ack_next  = 1'b1;
                    prio_next   = PRIO_B;
                end else if (grant_b) begin
                    wraddr_next = b_addr;
                    datain_next = b_data;
                    regwr_next  = !(DISCARD_R0 && (b_addr == 5'd0));
                    b_ack_next  = 1'b1;
                    prio_next   = PRIO_A;
                end
            end
            ST_CLEAR: begin
                regwr_next  = 1'b1;
                wraddr_next = cnt;
                datain_next = CLR_VALUE;
                if (cnt == 5'd31) begin
                    state_next = ST_IDLE;
                    cnt_next   = 5'd0;
                end else begin
                    cnt_next = cnt + 5'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            prio   <= PRIO_A;
            cnt    <= 5'd0;
            RegWr  <= 1'b0;
            WrAddr <= 5'd0;
            DataIn <= 32'd0;
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
        end else begin
            state  <= state_next;
            prio   <= prio_next;
            cnt    <= cnt_next;
            RegWr  <= regwr_next;
            WrAddr <= wraddr_next;
            DataIn <= datain_next;
            a_ack  <= a_ack_next;
            b_ack  <= b_ack_next;
        end
    end

    // Decoded straight from the state register, so it is registered with
    // the state and drops together with it on reset.
    assign clr_busy  = (state == ST_CLEAR);
    assign dbg_state = state;
    assign dbg_prio  = prio;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed testbench for rf_wr_arbiter with a register-file sink model.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        reset;
    logic        clr_req;
    logic        clr_busy;
    logic        a_req;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ack;
    logic        b_req;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ack;
    logic        RegWr;
    logic [4:0]  WrAddr;
    logic [31:0] DataIn;
    logic        dbg_state;
    logic        dbg_prio;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rf [32];

    rf_wr_arbiter #(
        .CLR_VALUE  (32'h0000_0000),
        .DISCARD_R0 (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ack     (a_ack),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ack     (b_ack),
        .RegWr     (RegWr),
        .WrAddr    (WrAddr),
        .DataIn    (DataIn),
        .dbg_state (dbg_state),
        .dbg_prio  (dbg_prio)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register file sink ----------------
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (reset && RegWr) rf[WrAddr] <= DataIn;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one A write and wait (bounded) for its ack; leaves a_req low.
    task automatic write_a(input logic [4:0] addr, input logic [31:0] data);
        logic seen;
        seen   = 1'b0;
        a_req  = 1'b1;
        a_addr = addr;
        a_data = data;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check("write_a_ack_seen", 32'(seen), 32'd1);
        a_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic found;
        reset   = 1'b0;
        clr_req = 1'b0;
        a_req   = 1'b0;
        a_addr  = 5'd0;
        a_data  = 32'd0;
        b_req   = 1'b0;
        b_addr  = 5'd0;
        b_data  = 32'd0;

        // Reset state
        repeat (2) step();
        check("rst_regwr",  32'(RegWr),     32'd0);
        check("rst_wraddr", 32'(WrAddr),    32'd0);
        check("rst_datain", DataIn,         32'd0);
        check("rst_a_ack",  32'(a_ack),     32'd0);
        check("rst_b_ack",  32'(b_ack),     32'd0);
        check("rst_busy",   32'(clr_busy),  32'd0);
        check("rst_state",  32'(dbg_state), 32'd0);
        check("rst_prio",   32'(dbg_prio),  32'd0);
        reset = 1'b1;

        // A alone, request held: grants 2 cycles apart
        a_req  = 1'b1;
        a_addr = 5'd5;
        a_data = 32'hDEAD_BEEF;
        step();
        check("a1_regwr",  32'(RegWr),  32'd1);
        check("a1_wraddr", 32'(WrAddr), 32'd5);
        check("a1_datain", DataIn,      32'hDEAD_BEEF);
        check("a1_ack",    32'(a_ack),  32'd1);
        check("a1_b_ack",  32'(b_ack),  32'd0);
        step();
        check("a1_mask_regwr", 32'(RegWr), 32'd0);
        check("a1_mask_ack",   32'(a_ack), 32'd0);
        check("a1_r5",         rf[5],      32'hDEAD_BEEF);
        step();
        check("a2_regwr", 32'(RegWr), 32'd1);
        check("a2_ack",   32'(a_ack), 32'd1);
        a_req = 1'b0;
        check("a2_prio_b", 32'(dbg_prio), 32'd1);
        step();
        check("a_idle_regwr", 32'(RegWr), 32'd0);

        // Contention from reset: A then B, then round-robin
        reset = 1'b0;
        #2;
        check("async_rst_prio", 32'(dbg_prio), 32'd0);
        reset = 1'b1;
        a_req = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        b_req = 1'b1; b_addr = 5'd4; b_data = 32'h22;
        step();
        check("c1_a_ack",  32'(a_ack),  32'd1);
        check("c1_b_ack",  32'(b_ack),  32'd0);
        check("c1_wraddr", 32'(WrAddr), 32'd3);
        check("c1_datain", DataIn,      32'h11);
        a_addr = 5'd8; a_data = 32'h33;            // A re-requests at once
        step();
        check("c2_b_ack",  32'(b_ack),  32'd1);
        check("c2_a_ack",  32'(a_ack),  32'd0);
        check("c2_wraddr", 32'(WrAddr), 32'd4);
        check("c2_datain", DataIn,      32'h22);
        check("c2_regwr",  32'(RegWr),  32'd1);
        b_req = 1'b0;
        step();
        check("c3_a_ack",  32'(a_ack),  32'd1);
        check("c3_wraddr", 32'(WrAddr), 32'd8);
        check("c3_regwr",  32'(RegWr),  32'd1);
        a_req = 1'b0;
        step();
        check("c4_idle_regwr", 32'(RegWr), 32'd0);
        check("c4_wraddr_hold", 32'(WrAddr), 32'd8);
        // Both fresh while prio points at B
        a_req = 1'b1; a_addr = 5'd9;  a_data = 32'h44;
        b_req = 1'b1; b_addr = 5'd10; b_data = 32'h66;
        step();
        check("c5_b_ack",  32'(b_ack),  32'd1);
        check("c5_a_ack",  32'(a_ack),  32'd0);
        check("c5_wraddr", 32'(WrAddr), 32'd10);
        b_req = 1'b0;
        step();
        check("c6_a_ack",  32'(a_ack),  32'd1);
        check("c6_wraddr", 32'(WrAddr), 32'd9);
        check("c6_datain", DataIn,      32'h44);
        a_req = 1'b0;
        step();
        check("c_r3",  rf[3],  32'h11);
        check("c_r4",  rf[4],  32'h22);
        check("c_r8",  rf[8],  32'h33);
        check("c_r10", rf[10], 32'h66);
        check("c_r9",  rf[9],  32'h44);

        // r0 discard
        b_req = 1'b1; b_addr = 5'd0; b_data = 32'h55;
        step();
        check("r0_b_ack", 32'(b_ack), 32'd1);
        check("r0_regwr", 32'(RegWr), 32'd0);
        b_req = 1'b0;
        step();
        check("r0_value", rf[0], 32'd0);

        // Clear with a pending A request
        clr_req = 1'b1;
        a_req = 1'b1; a_addr = 5'd7; a_data = 32'h7777_0007;
        step();
        clr_req = 1'b0;
        check("clr_e0_busy",  32'(clr_busy), 32'd1);
        check("clr_e0_regwr", 32'(RegWr),    32'd0);
        check("clr_e0_a_ack", 32'(a_ack),    32'd0);
        for (int k = 1; k <= 31; k++) begin
            step();
            check("clr_regwr",  32'(RegWr),    32'd1);
            check("clr_wraddr", 32'(WrAddr),   32'(k));
            check("clr_datain", DataIn,        32'd0);
            check("clr_busy",   32'(clr_busy), (k < 31) ? 32'd1 : 32'd0);
            check("clr_a_ack",  32'(a_ack),    32'd0);
        end
        step();
        check("clr_post_a_ack",  32'(a_ack),    32'd1);
        check("clr_post_wraddr", 32'(WrAddr),   32'd7);
        check("clr_post_datain", DataIn,        32'h7777_0007);
        check("clr_post_busy",   32'(clr_busy), 32'd0);
        a_req = 1'b0;
        step();
        check("clr_r7",  rf[7],  32'h7777_0007);
        check("clr_r1",  rf[1],  32'd0);
        check("clr_r5",  rf[5],  32'd0);
        check("clr_r10", rf[10], 32'd0);
        check("clr_r31", rf[31], 32'd0);

        // Reset mid-clear
        write_a(5'd10, 32'h0000_0A10);
        write_a(5'd12, 32'h0000_0C12);
        write_a(5'd20, 32'h0000_0D20);
        step();
        check("pre_r12", rf[12], 32'h0000_0C12);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (RegWr && WrAddr == 5'd11) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_reach_r11", 32'(found), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_async_regwr", 32'(RegWr),    32'd0);
        check("mid_async_busy",  32'(clr_busy), 32'd0);
        check("mid_async_a_ack", 32'(a_ack),    32'd0);
        check("mid_async_wraddr", 32'(WrAddr),  32'd0);
        step();
        reset = 1'b1;
        check("mid_rel_state", 32'(dbg_state), 32'd0);
        check("mid_rel_prio",  32'(dbg_prio),  32'd0);
        step();
        check("mid_rel_regwr", 32'(RegWr),    32'd0);
        check("mid_rel_busy",  32'(clr_busy), 32'd0);
        step();
        check("mid_r10", rf[10], 32'd0);
        check("mid_r12", rf[12], 32'h0000_0C12);
        check("mid_r20", rf[20], 32'h0000_0D20);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
